// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding, width limits and byte width.
package alu_pkg;

  localparam int BYTE_W     = 8;
  localparam int NBYTES_MIN = 2;
  localparam int NBYTES_MAX = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } seq_state_e;

endpackage

// File: rtl/add_sequencer.sv
// Byte-serial multi-precision add/subtract controller driving the shared 8-bit adder.
// Operands are stepped LSB-first, one byte per clock, with the carry chained in cbit_q.
//
// state | meaning
// IDLE  | waiting for start; adder released (add_en = 0)
// RUN   | one operand byte per cycle through the adder
// DONE  | one-cycle done pulse; result/carry/overflow valid
module add_sequencer
  import alu_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       sub,
  input  logic [BYTE_W*NBYTES-1:0]   op_a,
  input  logic [BYTE_W*NBYTES-1:0]   op_b,
  output logic                       busy,
  output logic                       done,
  output logic [BYTE_W*NBYTES-1:0]   result,
  output logic                       carry,
  output logic                       overflow,
  output logic [BYTE_W-1:0]          add_a,
  output logic [BYTE_W-1:0]          add_b,
  output logic                       add_cin,
  output logic                       add_en,
  input  logic [BYTE_W-1:0]          add_s,
  input  logic                       add_cout,
  input  logic                       add_over
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  seq_state_e    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  result_q, result_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          cbit_q, cbit_d;
  logic          carry_q, carry_d;
  logic          overflow_q, overflow_d;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    idx_d      = idx_q;
    cbit_d     = cbit_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    add_en     = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // subtract as A + ~B + 1: the +1 enters as the byte-0 carry-in
          a_d      = op_a;
          b_d      = sub ? ~op_b : op_b;
          cbit_d   = sub;
          idx_d    = '0;
          result_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        add_en  = 1'b1;
        add_a   = a_q[{idx_q, 3'b000} +: BYTE_W];
        add_b   = b_q[{idx_q, 3'b000} +: BYTE_W];
        add_cin = cbit_q;
        result_d[{idx_q, 3'b000} +: BYTE_W] = add_s;
        cbit_d  = add_cout;
        if (idx_q == IDX_LAST) begin
          carry_d    = add_cout;
          overflow_d = add_over;
          state_d    = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      idx_q      <= '0;
      cbit_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      idx_q      <= idx_d;
      cbit_q     <= cbit_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_add_sequencer.sv
// Bench for add_sequencer with a tri-state 8-bit adder model on the add_* bus.
module tb_add_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic         add_en;
  wire  [7:0]   add_s;
  wire          add_cout;
  wire          add_over;

  logic [8:0] adder_t;
  assign adder_t  = {1'b0, add_a} + {1'b0, add_b} + 9'(add_cin);
  assign add_s    = add_en ? adder_t[7:0] : 8'bz;
  assign add_cout = add_en ? adder_t[8] : 1'bz;
  assign add_over = add_en ? ((add_a[7] == add_b[7]) && (adder_t[7] != add_a[7])) : 1'bz;

  add_sequencer #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .carry(carry), .overflow(overflow),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_en(add_en),
    .add_s(add_s), .add_cout(add_cout), .add_over(add_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  exp_t         sb_q[$];
  int           passed = 0;
  int           total  = 0;
  logic [W-1:0] last_res = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Whole-word reference plus the per-byte carry-in sequence the adder should see.
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c, output logic v,
                       output logic [NB-1:0] cins);
    logic [W:0]   t;
    logic [W-1:0] bb;
    logic [8:0]   bt;
    logic         cc;
    bb = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
    r  = t[W-1:0];
    c  = t[W];
    v  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    cc = s;
    for (int i = 0; i < NB; i++) begin
      cins[i] = cc;
      bt = {1'b0, a[i*8 +: 8]} + {1'b0, bb[i*8 +: 8]} + 9'(cc);
      cc = bt[8];
    end
  endtask

  // inj bit k drives a junk start in cycle k of the op (must be ignored).
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ec, input logic ev,
                        input logic [7:0] inj);
    logic [W-1:0]  mr;
    logic          mc, mv;
    logic [NB-1:0] cins;
    logic [W-1:0]  bb;
    exp_t          e;
    model(s, a, b, mr, mc, mv, cins);
    bb = s ? ~b : b;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("result_held", 64'(result), 64'(last_res));
    start = 1'b1; sub = s; op_a = a; op_b = b;
    sb_q.push_back('{r: er, c: ec, v: ev});
    for (int k = 1; k <= NB + 1; k++) begin
      @(negedge clk);
      chk($sformatf("add_en_c%0d", k), 64'(add_en), 64'(k <= NB));
      chk($sformatf("done_c%0d", k), 64'(done), 64'(k == NB + 1));
      chk($sformatf("busy_c%0d", k), 64'(busy), 64'd1);
      if (k <= NB) chk($sformatf("add_cin_c%0d", k), 64'(add_cin), 64'(cins[k-1]));
      if (k == 1) begin
        chk("add_a_c1", 64'(add_a), 64'(a[7:0]));
        chk("add_b_c1", 64'(add_b), 64'(bb[7:0]));
      end
      if (done && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("result", 64'(result), 64'(e.r));
        chk("carry", 64'(carry), 64'(e.c));
        chk("overflow", 64'(overflow), 64'(e.v));
        last_res = e.r;
      end
      if (inj[k]) begin
        start = 1'b1; sub = ~s; op_a = $urandom; op_b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    if (sb_q.size() != 0) begin
      total++;
      $display("FAIL done_timeout: got no done, required done in cycle %0d", NB + 1);
      sb_q.delete();
      last_res = result;
    end
  endtask

  vec_t vecs[8];

  initial begin
    logic [NB-1:0] dummy;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;

    vecs[0] = '{s: 1'b0, a: 32'h0000_00FF, b: 32'h0000_0001, r: 32'h0000_0100, c: 1'b0, v: 1'b0};
    vecs[1] = '{s: 1'b0, a: 32'h7FFF_FFFF, b: 32'h0000_0001, r: 32'h8000_0000, c: 1'b0, v: 1'b1};
    vecs[2] = '{s: 1'b0, a: 32'hFFFF_FFFF, b: 32'h0000_0001, r: 32'h0000_0000, c: 1'b1, v: 1'b0};
    vecs[3] = '{s: 1'b1, a: 32'h0000_0005, b: 32'h0000_0007, r: 32'hFFFF_FFFE, c: 1'b0, v: 1'b0};
    vecs[4] = '{s: 1'b1, a: 32'h8000_0000, b: 32'h0000_0001, r: 32'h7FFF_FFFF, c: 1'b1, v: 1'b1};
    for (int i = 5; i < 8; i++) begin
      vecs[i].s = 1'($urandom_range(0, 1));
      vecs[i].a = $urandom;
      vecs[i].b = $urandom;
      model(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].c, vecs[i].v, dummy);
    end

    #23;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_add_en", 64'(add_en), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_carry_ovf", 64'({carry, overflow, add_cin}), 64'd0);
    chk("rst_add_ab", 64'({add_a, add_b}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].c, vecs[i].v, 8'h00);

    // Junk starts in cycles 2 and 5 must be ignored; the following op starts in cycle 6.
    run_op(1'b0, 32'h1234_5678, 32'h0101_0101, 32'h1335_5779, 1'b0, 1'b0, 8'b0010_0100);
    run_op(1'b1, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 1'b1, 1'b0, 8'h00);

    // Asynchronous reset in cycle 3 aborts the op with no done.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_add_en", 64'(add_en), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_outs", 64'({done, carry, overflow, add_cin, add_a, add_b}), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    last_res = '0;
    run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/add_sequencer.md
Name: add_sequencer

Overview:
Byte-serial multi-precision add/subtract controller for the shared 8-bit ALU adder (enable-gated, tri-state outputs, carry in/out, overflow). It accepts one NBYTES-wide operation through a start/busy/done handshake. It then steps the adder over the operand bytes LSB-first, one byte per clock, chaining the carry. It sits between the CPU control unit and the adder, and it is the only block that drives the adder's en pin during a multi-byte op.

Parameters:
NBYTES, 4, operand width in bytes; legal range 2..8; operand width W = 8*NBYTES

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; sampled only in IDLE
sub  in  1  0 = A+B, 1 = A-B; sampled with start
op_a  in  W  operand A, sampled with start
op_b  in  W  operand B, sampled with start
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse; result, carry and overflow are valid from this cycle on
result  out  W  sum/difference; holds until the next accepted start
carry  out  1  final carry-out; for sub, 1 = no borrow
overflow  out  1  signed overflow of the full W-bit op
add_a  out  8  byte to adder input a
add_b  out  8  byte to adder input b (already inverted for sub)
add_cin  out  1  adder carry-in
add_en  out  1  adder enable; adder outputs are high-Z when 0
add_s  in  8  adder sum
add_cout  in  1  adder carry-out
add_over  in  1  adder overflow; meaningful only on the MSB byte

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE.
  - busy, done, add_en, add_cin = 0.
  - add_a, add_b, result, carry, overflow = 0.
  - A reset during RUN aborts the op. No done is produced, and add_en drops immediately, releasing the adder bus.
- States: IDLE, RUN, DONE. Encoding is binary, 2 bits.
- IDLE, start=1 (cycle 0):
  - Latch A = op_a.
  - Latch B = sub ? ~op_b : op_b.
  - cbit <= sub; idx <= 0; clear result.
  - Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, one byte per cycle (cycles 1..NBYTES):
  - Combinational outputs: add_en = 1, add_a = A[idx], add_b = B[idx], add_cin = cbit.
  - At the clock edge: result[idx] <= add_s; cbit <= add_cout; idx <= idx+1.
  - When idx = NBYTES-1: also capture overflow <= add_over and carry <= add_cout, then go to DONE.
- DONE (cycle NBYTES+1): done = 1 for exactly one cycle, add_en = 0, next state IDLE.
  - A start in this cycle is ignored; the earliest next accept is cycle NBYTES+2.
- Outside RUN: add_en = 0, add_a = add_b = 0, add_cin = 0. The adder's tri-state outputs are never sampled while add_en = 0.
- start while busy: ignored. No queueing and no error flag. Operand registers are not disturbed.
- Latency: start to done is NBYTES+1 clocks; throughput is one op per NBYTES+2 clocks.
- Width rules:
  - idx is ceil(log2(NBYTES)) bits and never wraps past NBYTES-1.
  - result bytes are written only at their own idx.
  - Subtract is two's complement via inverted B plus cin = 1 into byte 0.
- Intermediate-byte add_over is ignored; only the MSB-byte value is used.

Decomposition:
- Shared package alu_pkg:
  - state encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2
  - NBYTES_MIN = 2, NBYTES_MAX = 8
  - byte width constant BYTE_W = 8
- No sub-module. The adder stays external and is connected by the parent, so it can still be shared with other ALU paths when add_en = 0.
- The bench instantiates the real adder and connects it to the add_* ports.

Test Plan:
- NBYTES=4, start, sub=0, A=0x000000FF, B=0x00000001 -> done in cycle 5; result=0x00000100, carry=0, overflow=0; add_en high exactly in cycles 1-4.
- A=0x7FFFFFFF, B=0x00000001, add -> result=0x80000000, carry=0, overflow=1.
- A=0xFFFFFFFF, B=0x00000001, add -> result=0x00000000, carry=1, overflow=0.
- sub=1, A=0x00000005, B=0x00000007 -> result=0xFFFFFFFE, carry=0 (borrow), overflow=0; add_cin=1 in cycle 1 only.
- start pulsed again in cycles 2 and 5 with different operands -> both ignored; first result unchanged; next start in cycle 6 accepted.
- rst_n low mid-op in cycle 3 -> all outputs 0 asynchronously, add_en 0, no done; a fresh op after release completes normally.
